coms_frame_receiver: RTL
========================

Name: coms_frame_receiver

Overview:
- Motor-board side of the RS485 bus: directly downstream of the FPGA master's frame transmitter. Consumes bytes from the board's uart_rx.
- Hunts for the three master frame magic numbers, buffers the payload and checks CRC16.
- Filters by motor id, then latches setpoint and controller parameters for the local PID.
- Raises a one-cycle status_request pulse so the local status-frame transmitter answers the master.

Parameters:
- MOTOR_ID, 0, 8-bit bus address this board answers to.
- CLK_FREQ_HZ, 50_000_000, clock frequency.
- BAUDRATE, 2_000_000, bus bit rate.
- TIMEOUT_BITS, 20, inter-byte silence (in bit times) that aborts a partial frame.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  8  byte from uart_rx.
- rx_data_ready  in  1  level from uart_rx; a byte is taken on its rising edge only.
- setpoint  out  24 signed  commanded setpoint.
- neopxl_color  out  24  LED colour.
- control_mode  out  8  controller mode.
- Kp, Ki, Kd  out  16 signed each  gains.
- PWMLimit, IntegralLimit, deadband  out  24 signed each  limits.
- status_request  out  1  one-cycle pulse.
- setpoint_update  out  1  one-cycle pulse.
- control_mode_update  out  1  one-cycle pulse.
- crc_error_count  out  16  saturating counter.
- timeout_count  out  16  saturating counter.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to HUNT.
  - All outputs 0; magic window cleared; byte counter 0.
  - Reset mid-frame discards the partial frame.
- Byte accept: rx_data is taken when rx_data_ready==1 and its registered previous value ==0. Every accepted byte shifts into a 4-byte window, oldest byte first, in all states.
- Frames (magic is big-endian; CRC covers bytes 4..L-3; CRC hi then lo):
  - Status request: magic 0x1CE1CEBB, L=7; payload id.
  - Setpoint: magic 0xD0D0D0D0, L=13; payload id, setpoint[3], colour[3].
  - Control mode: magic 0xBAADA555, L=26; payload id, mode, Kp[2], Ki[2], Kd[2], PWMLimit[3], IntegralLimit[3], deadband[3], setpoint[3].
  - All multi-byte fields are MSB first.
- CRC16: polynomial x^16+x^15+x^2+1, init 0xFFFF, 8 bits per step, first serial bit D[7].
- HUNT:
  - When the accepted byte completes a window equal to one of the three magics, latch the frame type and expected payload length P=L-4, clear the counter and go to RECEIVE.
  - Any other window value: stay in HUNT.
- RECEIVE:
  - Each accepted byte is stored at buf[count] and count increments (buffer 22 bytes).
  - When count==P, go to CHECK.
  - Magic patterns inside the payload do not resync.
  - If no byte arrives for CLK_FREQ_HZ/BAUDRATE*TIMEOUT_BITS cycles: go to HUNT, timeout_count+1.
- CHECK:
  - The CRC is computed sequentially, one buffer byte per cycle, over buf[0..P-3]: P-2 cycles.
  - Then go to COMMIT.
  - Bytes arriving during CHECK/COMMIT only feed the window.
- COMMIT (1 cycle), then HUNT:
  - CRC mismatch with buf[P-2..P-1]: crc_error_count+1; no output change.
  - id != MOTOR_ID and id != 0xFF: drop silently; no counter change.
  - id == 0xFF (broadcast): setpoint and control-mode frames are applied; a status request is ignored.
  - Otherwise:
    - Status request: status_request pulse.
    - Setpoint: update setpoint and neopxl_color; setpoint_update pulse.
    - Control mode: update all parameters and setpoint; control_mode_update pulse.
- Latency: outputs and pulse are visible P-2+2 cycles after the clk edge that accepted the final CRC byte.
- Counters saturate at 0xFFFF and never wrap.
- Pulses are exactly one cycle long and never overlap.

Decomposition:
- Package coms_pkg holds:
  - the three magic numbers;
  - the frame lengths 7/13/26;
  - MAGIC_NUMBER_LENGTH=4 and MAX_PAYLOAD=22;
  - the CRC init 0xFFFF;
  - function nextCRC16_D8;
  - a frame_type_t enum (NONE, STATUS_REQ, SETPOINT, CONTROL_MODE).
- The master transmitter is to import the same package.
- One sub-module, crc16_serial: start, byte_valid, byte_in, crc_out; one byte per cycle.

Test Plan:
- Valid status request from the golden-model CRC, id=MOTOR_ID=3 -> one status_request pulse at the stated latency; crc_error_count stays 0.
- Setpoint frame, id 3, setpoint 0xFFF000, colour 0x00FF00 -> setpoint = -4096, neopxl_color = 0x00FF00, one setpoint_update pulse.
- Control-mode frame with the last CRC byte XOR 0x01 -> no output change, crc_error_count = 1.
- Setpoint frame with id 7 -> ignored. Broadcast id 0xFF setpoint frame -> applied. Broadcast status request -> no pulse.
- Control-mode frame stalled after byte 10 for 501 cycles (50 MHz, 2 Mbaud, 20 bits) -> timeout_count = 1. A following valid frame is then accepted normally.
- Reset asserted mid-setpoint frame -> outputs 0, HUNT. A back-to-back magic inside the payload does not resync; the frame completes on count.

Source files
------------

// File: rtl/coms_pkg.sv
// Shared frame definitions for the RS485 master/motor link: magics, frame lengths and CRC16.
// Both the master frame transmitter and the motor-board receiver import this package.
package coms_pkg;

  localparam logic [31:0] MAGIC_STATUS_REQ   = 32'h1CE1CEBB;
  localparam logic [31:0] MAGIC_SETPOINT     = 32'hD0D0D0D0;
  localparam logic [31:0] MAGIC_CONTROL_MODE = 32'hBAADA555;

  localparam int LEN_STATUS_REQ   = 7;
  localparam int LEN_SETPOINT     = 13;
  localparam int LEN_CONTROL_MODE = 26;

  localparam int MAGIC_NUMBER_LENGTH = 4;
  localparam int MAX_PAYLOAD         = 22;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    NONE,
    STATUS_REQ,
    SETPOINT,
    CONTROL_MODE
  } frame_type_t;

  // Polynomial x^16+x^15+x^2+1, data[7] enters the register first.
  function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data, input logic [15:0] crc);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Byte-serial CRC16 accumulator: start reloads the seed, each byte_valid folds in one byte.
// Result is registered one cycle after the byte; no backpressure, accepts a byte every cycle.
module crc16_serial
  import coms_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_out <= CRC16_INIT;
    end else if (start) begin
      crc_out <= CRC16_INIT;
    end else if (byte_valid) begin
      crc_out <= nextCRC16_D8(byte_in, crc_out);
    end
  end

endmodule

// File: rtl/coms_frame_receiver.sv
// Motor-board frame receiver: hunts magics, buffers payload, checks CRC16, filters by id, latches PID settings.
// Outputs land P cycles after the final byte is accepted; no backpressure, late bytes only feed the magic window.
module coms_frame_receiver
  import coms_pkg::*;
#(
  parameter logic [7:0] MOTOR_ID     = 8'd0,
  parameter int         CLK_FREQ_HZ  = 50_000_000,
  parameter int         BAUDRATE     = 2_000_000,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_data_ready,
  output logic signed [23:0] setpoint,
  output logic [23:0]        neopxl_color,
  output logic [7:0]         control_mode,
  output logic signed [15:0] Kp,
  output logic signed [15:0] Ki,
  output logic signed [15:0] Kd,
  output logic signed [23:0] PWMLimit,
  output logic signed [23:0] IntegralLimit,
  output logic signed [23:0] deadband,
  output logic               status_request,
  output logic               setpoint_update,
  output logic               control_mode_update,
  output logic [15:0]        crc_error_count,
  output logic [15:0]        timeout_count
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / BAUDRATE * TIMEOUT_BITS;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] RECEIVE = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] COMMIT  = 2'd3;

  logic [1:0]    state;
  logic          rdy_q;
  logic          byte_vld;
  logic [7:0]    byte_dat;
  logic [23:0]   window;
  logic [31:0]   win_next;
  frame_type_t   ftype;
  frame_type_t   hit_type;
  logic [4:0]    hit_len;
  logic [4:0]    plen;
  logic [4:0]    count;
  logic [4:0]    crc_idx;
  logic [TW-1:0] timer;
  logic [7:0]    frame_buf [MAX_PAYLOAD];
  logic [15:0]   crc_out;
  logic [15:0]   rx_crc;
  logic [7:0]    frame_id;
  logic          magic_hit;
  logic          crc_ok;
  logic          id_unicast;
  logic          id_bcast;

  // The 4-byte magic window is the three stored bytes plus the byte being consumed.
  assign win_next = {window, byte_dat};

  always_comb begin
    hit_type = NONE;
    hit_len  = 5'd0;
    if (win_next == MAGIC_STATUS_REQ) begin
      hit_type = STATUS_REQ;
      hit_len  = 5'(LEN_STATUS_REQ - MAGIC_NUMBER_LENGTH);
    end else if (win_next == MAGIC_SETPOINT) begin
      hit_type = SETPOINT;
      hit_len  = 5'(LEN_SETPOINT - MAGIC_NUMBER_LENGTH);
    end else if (win_next == MAGIC_CONTROL_MODE) begin
      hit_type = CONTROL_MODE;
      hit_len  = 5'(LEN_CONTROL_MODE - MAGIC_NUMBER_LENGTH);
    end
  end

  assign magic_hit  = (state == HUNT) && byte_vld && (hit_type != NONE);
  assign rx_crc     = {frame_buf[plen - 5'd2], frame_buf[plen - 5'd1]};
  assign frame_id   = frame_buf[0];
  assign crc_ok     = (crc_out == rx_crc);
  assign id_bcast   = (frame_id == 8'hFF);
  assign id_unicast = (frame_id == MOTOR_ID) && !id_bcast;

  crc16_serial u_crc (
    .clk        (clk),
    .reset      (reset),
    .start      (magic_hit),
    .byte_valid (state == CHECK),
    .byte_in    (frame_buf[crc_idx]),
    .crc_out    (crc_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q         <= 1'b0;
      byte_vld      <= 1'b0;
      byte_dat      <= 8'd0;
      window        <= 24'd0;
      state         <= HUNT;
      ftype         <= NONE;
      plen          <= 5'd0;
      count         <= 5'd0;
      crc_idx       <= 5'd0;
      timer         <= '0;
      timeout_count <= 16'd0;
    end else begin
      rdy_q    <= rx_data_ready;
      byte_vld <= rx_data_ready & ~rdy_q;
      byte_dat <= rx_data;
      if (byte_vld) window <= win_next[23:0];
      case (state)
        HUNT: begin
          if (magic_hit) begin
            ftype <= hit_type;
            plen  <= hit_len;
            count <= 5'd0;
            timer <= '0;
            state <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (byte_vld) begin
            count <= count + 5'd1;
            timer <= '0;
            if (count + 5'd1 == plen) begin
              crc_idx <= 5'd0;
              state   <= CHECK;
            end
          end else if (timer == TIMEOUT_LAST) begin
            state <= HUNT;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CHECK: begin
          crc_idx <= crc_idx + 5'd1;
          if (crc_idx == plen - 5'd3) state <= COMMIT;
        end
        default: state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RECEIVE && byte_vld) frame_buf[count] <= byte_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      setpoint            <= '0;
      neopxl_color        <= '0;
      control_mode        <= '0;
      Kp                  <= '0;
      Ki                  <= '0;
      Kd                  <= '0;
      PWMLimit            <= '0;
      IntegralLimit       <= '0;
      deadband            <= '0;
      status_request      <= 1'b0;
      setpoint_update     <= 1'b0;
      control_mode_update <= 1'b0;
      crc_error_count     <= 16'd0;
    end else begin
      status_request      <= 1'b0;
      setpoint_update     <= 1'b0;
      control_mode_update <= 1'b0;
      if (state == COMMIT) begin
        if (!crc_ok) begin
          if (crc_error_count != 16'hFFFF) crc_error_count <= crc_error_count + 16'd1;
        end else if (id_unicast || id_bcast) begin
          case (ftype)
            STATUS_REQ: status_request <= id_unicast;
            SETPOINT: begin
              setpoint        <= {frame_buf[1], frame_buf[2], frame_buf[3]};
              neopxl_color    <= {frame_buf[4], frame_buf[5], frame_buf[6]};
              setpoint_update <= 1'b1;
            end
            CONTROL_MODE: begin
              control_mode        <= frame_buf[1];
              Kp                  <= {frame_buf[2], frame_buf[3]};
              Ki                  <= {frame_buf[4], frame_buf[5]};
              Kd                  <= {frame_buf[6], frame_buf[7]};
              PWMLimit            <= {frame_buf[8], frame_buf[9], frame_buf[10]};
              IntegralLimit       <= {frame_buf[11], frame_buf[12], frame_buf[13]};
              deadband            <= {frame_buf[14], frame_buf[15], frame_buf[16]};
              setpoint            <= {frame_buf[17], frame_buf[18], frame_buf[19]};
              control_mode_update <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
